iob_2p_assim_fifo_n2w: RTL and testbench
========================================

# iob_2p_assim_fifo_n2w

Synchronous asymmetric FIFO with a narrow write port and a wide read port. It is the reverse of the tiled wide-write/narrow-read memory: narrow producer words are packed into wide words and drained by a wide consumer. Storage is RATIO banks of narrow 2-port RAM, and the block keeps its own occupancy and flag logic. It sits between a 16-bit stream source and a 32-bit bus-side reader.

## Interface
- W_DATA_W, 16, write (narrow) data width
- R_DATA_W, 32, read (wide) data width; R_DATA_W/W_DATA_W = RATIO, must be a power of 2 and at least 2
- ADDR_W, 10, log2 of capacity in narrow words (depth 2**ADDR_W narrow = 2**ADDR_W/RATIO wide)
- USE_RAM, 0, forwarded to the storage banks

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- w_en  in  1  write request
- data_in  in  W_DATA_W  narrow write data
- r_en  in  1  read request
- data_out  out  R_DATA_W  wide read data, registered
- full  out  1  no narrow slot free
- empty  out  1  fewer than RATIO narrow words stored (no complete wide word)
- level  out  ADDR_W+1  stored narrow-word count
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
- Write pointer wp: ADDR_W bits, counts narrow words. Read pointer rp: ADDR_W-log2(RATIO) bits, counts wide words. Both wrap modulo depth.
- Packing is little-endian. Narrow word k of a wide word goes to data_out bits [k*W_DATA_W +: W_DATA_W]. The first-written narrow word lands in the LSBs.
- Storage: RATIO banks, each 2**ADDR_W/RATIO deep and W_DATA_W wide. A write goes to bank wp[log2(RATIO)-1:0] at address wp[ADDR_W-1:log2(RATIO)]. A read reads all banks at address rp.
- Write accepted iff w_en && !full. Then the word is stored, wp increments and level increments by 1.
- Read accepted iff r_en && !empty. Then rp increments and level decrements by RATIO.
- Both accepted in the same cycle: level changes by 1-RATIO. Acceptance uses current-cycle flags only.
- A write while full is rejected even if a read is accepted in the same cycle.
- A read while empty is rejected even if a write completes a wide word in the same cycle.
- A rejected write leaves storage, wp and level unchanged and sets overflow to 1 for the next cycle.
- A rejected read leaves rp, level and data_out unchanged and sets underflow to 1 for the next cycle.
- Flags are registered and derived from the next level value:
  - full = (level == 2**ADDR_W)
  - empty = (level < RATIO)
- A partial wide word (level mod RATIO ≠ 0) stays buffered until its remaining narrow words arrive. There is no flush.
- Reset values: wp=0, rp=0, level=0, empty=1, full=0, overflow=0, underflow=0, data_out=0. Memory contents are undefined after reset.

## Timing
- Write to level update: 1 cycle. A written word counts in level and the flags on the edge following acceptance.
- Read latency: 1 cycle. data_out holds the accepted wide word from the edge after acceptance and keeps it until the next accepted read.
- No read-during-write hazard. A wide word becomes readable only after its last narrow write has been counted, so no bypass path exists.
- Back-to-back reads every cycle are sustained while level ≥ RATIO.
- Back-to-back writes every cycle are sustained until full.
- rst_n assertion mid-operation immediately clears all state asynchronously. Release is synchronous to clk by the integrator.

## Test plan
Bench parameters: W_DATA_W=16, R_DATA_W=32, ADDR_W=4 (16 narrow / 8 wide).
- Reset check: after rst_n=0→1, outputs show empty=1, full=0, level=0, data_out=0. An r_en pulse then gives underflow=1 for one cycle, with level and data_out unchanged.
- Packing order: write 0x1111 then 0x2222, then r_en. data_out=0x22221111 one cycle later, empty=1, level=0.
- Fill to full: write 0x0000..0x000F. full=1 and level=16. A 17th write (0xDEAD) gives overflow=1 and level stays 16. Eight reads return 0x00010000, 0x00030002, …, 0x000F000E, then empty=1.
- Simultaneous ops at full: at level=16, assert w_en=1 and r_en=1 together. The read is accepted, the write is rejected (overflow=1), and level=14.
- Wrap-around: run 40 narrow writes and 20 reads interleaved with random gaps. Every read matches the scoreboard across multiple wrap-arounds of wp and rp, with no overflow or underflow.
- Partial word and reset mid-operation: write 3 narrow words (level=3, empty=0), then pulse rst_n low between edges. Outputs return to their reset values at once, and a subsequent write/read pair of 0xAAAA, 0xBBBB returns 0xBBBBAAAA.

Source files
------------

// File: rtl/iob_2p_assim_fifo_n2w.sv
// ============================================================================
// Module   : iob_2p_assim_fifo_n2w
// Brief    : Narrow-write / wide-read FIFO packing narrow words little-endian
// Revision : 1.0
// ============================================================================
`default_nettype none

module iob_2p_assim_fifo_n2w #(
  parameter int W_DATA_W = 16,
  parameter int R_DATA_W = 32,
  parameter int ADDR_W   = 10,
  parameter int USE_RAM  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] data_in,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] data_out,
  output logic                full,
  output logic                empty,
  output logic [ADDR_W:0]     level,
  output logic                overflow,
  output logic                underflow
);

  localparam int RATIO   = R_DATA_W / W_DATA_W;
  localparam int LOG_R   = $clog2(RATIO);
  localparam int B_ADDR_W = ADDR_W - LOG_R;
  localparam int B_DEPTH = 2 ** B_ADDR_W;
  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] C_RATIO = (ADDR_W+1)'(RATIO);

  logic [ADDR_W-1:0]   r_wp;
  logic [B_ADDR_W-1:0] r_rp;
  logic [ADDR_W:0]     r_level;
  logic                r_full;
  logic                r_empty;
  logic                r_overflow;
  logic                r_underflow;

  logic                w_wr_acc;
  logic                w_rd_acc;
  logic [ADDR_W:0]     w_level_nxt;

  // Acceptance uses only the registered flags of this cycle.
  assign w_wr_acc = w_en && !r_full;
  assign w_rd_acc = r_en && !r_empty;

  always_comb begin
    w_level_nxt = r_level;
    if (w_wr_acc) w_level_nxt = w_level_nxt + (ADDR_W+1)'(1);
    if (w_rd_acc) w_level_nxt = w_level_nxt - C_RATIO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_level     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wp <= r_wp + ADDR_W'(1);
      if (w_rd_acc) r_rp <= r_rp + B_ADDR_W'(1);
      r_level     <= w_level_nxt;
      r_full      <= (w_level_nxt == C_DEPTH);
      r_empty     <= (w_level_nxt < C_RATIO);
      r_overflow  <= w_en && r_full;
      r_underflow <= r_en && r_empty;
    end
  end

  genvar g;
  generate
    for (g = 0; g < RATIO; g++) begin : g_bank
      logic [W_DATA_W-1:0] mem [B_DEPTH];
      logic [W_DATA_W-1:0] w_q;
      logic                w_bank_we;

      assign w_bank_we = w_wr_acc && (r_wp[LOG_R-1:0] == LOG_R'(g));

      always_ff @(posedge clk) begin
        if (w_bank_we) mem[r_wp[ADDR_W-1:LOG_R]] <= data_in;
      end

      if (USE_RAM != 0) begin : g_ram
        // Unreset read register keeps the array RAM-inferable; a valid bit
        // masks it to zero until the first accepted read.
        logic [W_DATA_W-1:0] r_q;
        logic                r_valid;

        always_ff @(posedge clk) begin
          if (w_rd_acc) r_q <= mem[r_rp];
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)        r_valid <= 1'b0;
          else if (w_rd_acc) r_valid <= 1'b1;
        end

        assign w_q = r_valid ? r_q : '0;
      end else begin : g_flop
        logic [W_DATA_W-1:0] r_q;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)        r_q <= '0;
          else if (w_rd_acc) r_q <= mem[r_rp];
        end

        assign w_q = r_q;
      end

      assign data_out[g*W_DATA_W +: W_DATA_W] = w_q;
    end
  endgenerate

  assign full      = r_full;
  assign empty     = r_empty;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_iob_2p_assim_fifo_n2w.sv
// ============================================================================
// Module   : tb_iob_2p_assim_fifo_n2w
// Brief    : Directed self-checking bench for the narrow-write/wide-read FIFO
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_iob_2p_assim_fifo_n2w;

  localparam int W_DATA_W = 16;
  localparam int R_DATA_W = 32;
  localparam int ADDR_W   = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                w_en;
  logic [W_DATA_W-1:0] data_in;
  logic                r_en;
  logic [R_DATA_W-1:0] data_out;
  logic                full;
  logic                empty;
  logic [ADDR_W:0]     level;
  logic                overflow;
  logic                underflow;

  int n_checks = 0;
  int n_errors = 0;

  iob_2p_assim_fifo_n2w #(
    .W_DATA_W(W_DATA_W),
    .R_DATA_W(R_DATA_W),
    .ADDR_W  (ADDR_W),
    .USE_RAM (0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .w_en     (w_en),
    .data_in  (data_in),
    .r_en     (r_en),
    .data_out (data_out),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] d);
    w_en = 1'b1; data_in = d;
    tick();
    w_en = 1'b0;
  endtask

  task automatic rd();
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] q[$];
    int          model_lvl;
    int          wr_left;
    int          rd_left;
    int          cyc;
    logic        do_w;
    logic        do_r;
    logic [31:0] exp_word;
    logic [15:0] wval;

    rst_n = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state and underflow on empty read
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_dout", data_out, 32'h0);
    rd();
    chk("uf_pulse", 32'(underflow), 32'd1);
    chk("uf_level", 32'(level), 32'd0);
    chk("uf_dout", data_out, 32'h0);
    tick();
    chk("uf_clear", 32'(underflow), 32'd0);

    // Packing order
    wr(16'h1111);
    chk("pk_half_empty", 32'(empty), 32'd1);
    chk("pk_half_level", 32'(level), 32'd1);
    wr(16'h2222);
    chk("pk_level2", 32'(level), 32'd2);
    chk("pk_notempty", 32'(empty), 32'd0);
    rd();
    chk("pk_dout", data_out, 32'h22221111);
    chk("pk_empty", 32'(empty), 32'd1);
    chk("pk_level0", 32'(level), 32'd0);

    // Fill to full, overflow, drain
    for (int i = 0; i < 16; i++) wr(16'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd16);
    wr(16'hDEAD);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd16);
    tick();
    chk("ovf_clear", 32'(overflow), 32'd0);
    for (int k = 0; k < 8; k++) begin
      rd();
      chk("drain_dout", data_out, {16'(2*k+1), 16'(2*k)});
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_level", 32'(level), 32'd0);

    // Simultaneous write and read while full
    for (int i = 0; i < 16; i++) wr(16'h0100 + 16'(i));
    chk("sim_full", 32'(full), 32'd1);
    w_en = 1'b1; r_en = 1'b1; data_in = 16'hBEEF;
    tick();
    w_en = 1'b0; r_en = 1'b0;
    chk("sim_ovf", 32'(overflow), 32'd1);
    chk("sim_uf", 32'(underflow), 32'd0);
    chk("sim_level", 32'(level), 32'd14);
    chk("sim_dout", data_out, 32'h01010100);
    chk("sim_notfull", 32'(full), 32'd0);
    for (int k = 1; k < 8; k++) begin
      rd();
      chk("sim_drain", data_out, {16'h0100 + 16'(2*k+1), 16'h0100 + 16'(2*k)});
    end
    chk("sim_empty", 32'(empty), 32'd1);

    // Wrap-around with random gaps against a queue scoreboard
    model_lvl = 0; wr_left = 40; rd_left = 20; cyc = 0;
    while ((wr_left > 0 || rd_left > 0) && cyc < 1000) begin
      cyc++;
      do_w = (wr_left > 0) && (model_lvl < 16) && ($urandom_range(0, 2) != 0);
      do_r = (rd_left > 0) && (model_lvl >= 2) && ($urandom_range(0, 2) == 0);
      wval = 16'($urandom);
      w_en = do_w; data_in = wval; r_en = do_r;
      if (do_r) begin
        exp_word[15:0]  = q.pop_front();
        exp_word[31:16] = q.pop_front();
        model_lvl -= 2;
        rd_left--;
      end
      if (do_w) begin
        q.push_back(wval);
        model_lvl++;
        wr_left--;
      end
      tick();
      w_en = 1'b0; r_en = 1'b0;
      if (do_r) chk("wrap_dout", data_out, exp_word);
      if (overflow || underflow) chk("wrap_flags", {30'd0, overflow, underflow}, 32'd0);
    end
    chk("wrap_done", 32'(wr_left + rd_left), 32'd0);
    chk("wrap_level", 32'(level), 32'(model_lvl));

    // Partial word then asynchronous reset between edges
    wr(16'h0001); wr(16'h0002); wr(16'h0003);
    chk("part_level", 32'(level), 32'd3);
    chk("part_empty", 32'(empty), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_dout", data_out, 32'h0);
    #2 rst_n = 1'b1;
    wr(16'hAAAA);
    wr(16'hBBBB);
    rd();
    chk("post_rst_dout", data_out, 32'hBBBBAAAA);
    chk("post_rst_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
